// File: rtl/wb_mem_pkg.sv
// Shared types and constants for the Wishbone-to-QSPI read cache.
package wb_mem_pkg;
  typedef enum logic [1:0] {IDLE, FILL, WRITE, ACK} state_t;

  localparam logic REGION_ROM = 1'b0;
  localparam logic REGION_RAM = 1'b1;
  localparam int   QSPI_ADR_W = 22;
endpackage

// File: rtl/wb_mem_cache_store.sv
// Direct-mapped line store: valid/tag/data arrays with async read,
// single write port (allocate, byte merge, invalidate) and global clear.
module wb_mem_cache_store #(
  parameter int LINES = 8,
  parameter int TAG_W = 20,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic             clear_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [31:0]      rd_data_o,
  input  logic             alloc_i,
  input  logic             merge_i,
  input  logic             inval_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [3:0]       wr_be_i,
  input  logic [31:0]      wr_data_i
);
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

  // Clear wins over any same-cycle allocate so a flushed fill never sticks.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= '0;
    end else if (clear_i) begin
      valid_q <= '0;
    end else if (alloc_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end else if (inval_i) begin
      valid_q[wr_idx_i] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (alloc_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end else if (merge_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_i[b]) data_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end
endmodule

// File: rtl/wb_mem_cache.sv
// Direct-mapped, write-through read cache in front of wb_qspi_mem.
// Define WB_MEM_CACHE_RAM_EN to also cache RAM-region reads.
module wb_mem_cache
  import wb_mem_pkg::*;
#(
  parameter int LINES = 8,
  parameter int ADR_W = 23
) (
  input  logic                  clk_i,
  input  logic                  rst_in,
  input  logic                  flush_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_be_i,
  input  logic [ADR_W-1:0]      wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic                  wb_ack_o,
  output logic [31:0]           wb_dat_o,
  output logic                  mem_sel_rom_ram_o,
  output logic                  mem_stb_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [QSPI_ADR_W-1:0] mem_adr_o,
  output logic [31:0]           mem_dat_o,
  input  logic                  mem_ack_i,
  input  logic [31:0]           mem_dat_i,
  output state_t                dbg_state_o
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADR_W - IDX_W;

  state_t           state_q;
  logic [ADR_W-1:0] req_adr_q;

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] cmp_tag, rd_tag;
  logic             rd_valid, line_match, hit;
  logic [31:0]      rd_data;
  logic             alloc, merge, inval, wr_match;

  function automatic logic cacheable(input logic region);
`ifdef WB_MEM_CACHE_RAM_EN
    cacheable = 1'b1;
`else
    cacheable = (region == REGION_ROM);
`endif
  endfunction

  // Look up the incoming address while idle, the latched request otherwise.
  always_comb begin
    rd_idx  = req_adr_q[IDX_W-1:0];
    cmp_tag = req_adr_q[ADR_W-1:IDX_W];
    if (state_q == IDLE) begin
      rd_idx  = wb_adr_i[IDX_W-1:0];
      cmp_tag = wb_adr_i[ADR_W-1:IDX_W];
    end
  end

  assign line_match = rd_valid && (rd_tag == cmp_tag);
  assign hit        = line_match && cacheable(wb_adr_i[ADR_W-1]);
  assign alloc      = (state_q == FILL) && mem_ack_i && !flush_i && cacheable(req_adr_q[ADR_W-1]);
  assign wr_match   = (state_q == WRITE) && mem_ack_i && line_match;
  assign inval      = wr_match && (req_adr_q[ADR_W-1] == REGION_ROM);
`ifdef WB_MEM_CACHE_RAM_EN
  assign merge      = wr_match && (req_adr_q[ADR_W-1] == REGION_RAM);
`else
  assign merge      = 1'b0;
`endif

  wb_mem_cache_store #(.LINES(LINES), .TAG_W(TAG_W)) u_store (
    .clk_i      (clk_i),
    .rst_in     (rst_in),
    .clear_i    (flush_i),
    .rd_idx_i   (rd_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .alloc_i    (alloc),
    .merge_i    (merge),
    .inval_i    (inval),
    .wr_idx_i   (req_adr_q[IDX_W-1:0]),
    .wr_tag_i   (req_adr_q[ADR_W-1:IDX_W]),
    .wr_be_i    (mem_be_o),
    .wr_data_i  ((state_q == FILL) ? mem_dat_i : mem_dat_o)
  );

  assign dbg_state_o = state_q;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q           <= IDLE;
      req_adr_q         <= '0;
      wb_ack_o          <= 1'b0;
      wb_dat_o          <= '0;
      mem_sel_rom_ram_o <= 1'b0;
      mem_stb_o         <= 1'b0;
      mem_we_o          <= 1'b0;
      mem_be_o          <= '0;
      mem_adr_o         <= '0;
      mem_dat_o         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wb_stb_i) begin
            req_adr_q         <= wb_adr_i;
            mem_adr_o         <= wb_adr_i[QSPI_ADR_W-1:0];
            mem_be_o          <= wb_be_i;
            mem_dat_o         <= wb_dat_i;
            mem_we_o          <= wb_we_i;
            // Writes always land in RAM, even when addressed to the ROM region.
            mem_sel_rom_ram_o <= wb_we_i ? REGION_RAM : wb_adr_i[ADR_W-1];
            if (wb_we_i) begin
              mem_stb_o <= 1'b1;
              state_q   <= WRITE;
            end else if (hit) begin
              wb_dat_o  <= rd_data;
              wb_ack_o  <= 1'b1;
              state_q   <= ACK;
            end else begin
              mem_stb_o <= 1'b1;
              state_q   <= FILL;
            end
          end
        end
        FILL: begin
          if (mem_ack_i) begin
            mem_stb_o <= 1'b0;
            wb_dat_o  <= mem_dat_i;
            wb_ack_o  <= 1'b1;
            state_q   <= ACK;
          end
        end
        WRITE: begin
          if (mem_ack_i) begin
            mem_stb_o <= 1'b0;
            mem_we_o  <= 1'b0;
            wb_ack_o  <= 1'b1;
            state_q   <= ACK;
          end
        end
        ACK: begin
          wb_ack_o <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
